scan_sequencer: RTL
===================

# scan_sequencer

Write-side controller for the tactile sensor array. It drives one switch (excitation) wire at a time and steps the read-wire mux across every read wire. For each sensor point it waits for the analog path to settle, triggers one ADC conversion and captures the result. It then issues a single-cycle write (indices + 12-bit sample + valid) into the frame storage array on the write clock domain.

## Interface
Parameters:
- SW_WIRE_CNT, 16, number of switch wires (≥2)
- RD_WIRE_CNT, 16, number of read wires (≥2)
- SW_SETTLE, 64, cycles to hold after selecting a new switch wire (≥1)
- RD_SETTLE, 4, cycles to hold after changing the read mux (≥1)
- ADC_TIMEOUT, 255, max cycles waiting for adc_valid (≥2)

Ports (one clock; reset is asynchronous, active-low):
- clk_write  in  1  write-domain clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE, begins a frame
- continuous  in  1  sampled at end of frame; 1 = start next frame immediately
- abort  in  1  synchronous abort to IDLE
- sw_en  out  1  switch-wire driver enable
- sw_sel  out  $clog2(SW_WIRE_CNT)+1  active switch wire index
- rd_sel  out  $clog2(RD_WIRE_CNT)+1  read mux select
- adc_start  out  1  one-cycle conversion request
- adc_valid  in  1  conversion result valid (one cycle)
- adc_data  in  12  conversion result
- sw_write_out  out  $clog2(SW_WIRE_CNT)+1  storage write switch index
- rd_write_out  out  $clog2(RD_WIRE_CNT)+1  storage write read index
- data_out  out  12  storage write data
- data_valid_out  out  1  storage write enable, one cycle per point
- frame_done  out  1  one-cycle pulse after last point of a frame
- busy  out  1  high in every state except IDLE
- adc_err  out  1  sticky: a conversion timed out

## Operation
- States: IDLE, SW_SETTLE, RD_SETTLE, CONVERT, WAIT, WRITE.
- IDLE: sw_en=0. If start=1, then next cycle: sw_sel=0, rd_sel=0, sw_en=1, adc_err cleared, state SW_SETTLE.
- SW_SETTLE: stay exactly SW_SETTLE cycles, then RD_SETTLE.
- RD_SETTLE: stay exactly RD_SETTLE cycles, then CONVERT.
- CONVERT: adc_start=1 for this single cycle, then WAIT.
- WAIT: on adc_valid, register adc_data and go to WRITE. adc_valid in any other state is ignored.
- WAIT timeout: after ADC_TIMEOUT cycles in WAIT without adc_valid, register 12'hFFF, set adc_err, go to WRITE.
- WRITE: data_valid_out=1 with sw_write_out=sw_sel, rd_write_out=rd_sel, data_out=captured sample. Next state:
  - rd_sel<RD_WIRE_CNT-1: rd_sel+1, go to RD_SETTLE.
  - else if sw_sel<SW_WIRE_CNT-1: sw_sel+1, rd_sel=0, go to SW_SETTLE.
  - else: frame_done=1 next cycle. If continuous=1: sw_sel=rd_sel=0, go to SW_SETTLE. Otherwise go to IDLE.
- Index order is row-major: rd fastest, sw slowest. Exactly SW_WIRE_CNT*RD_WIRE_CNT writes per frame; no index ever exceeds CNT-1.
- abort=1 in any state: next cycle IDLE, sw_en=0, no data_valid_out, no frame_done; a pending sample is discarded. Abort has priority over adc_valid and over the WRITE transition.
- adc_err stays set until the next accepted start.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Asynchronous assert, synchronous deassert (external synchronizer).
- start to first adc_start: 1 + SW_SETTLE + RD_SETTLE cycles.
- adc_valid in cycle t → data_valid_out in cycle t+1.
- Per-point period, same switch wire: RD_SETTLE + 1 + N + 1, where N = cycles from adc_start to adc_valid.
- frame_done is asserted in the cycle after the final WRITE. With continuous=1, SW_SETTLE of the next frame begins in that same cycle.
- sw_write_out, rd_write_out and data_out are stable while data_valid_out=1. Outside WRITE they hold their last value.

## Test plan
- Full frame: SW=4, RD=4, SW_SETTLE=3, RD_SETTLE=2; ADC model returns {sw,rd,4'h0} 5 cycles after adc_start → 16 writes in order (0,0)…(3,3) with matching data, then one frame_done, busy=0, and first adc_start 6 cycles after start.
- Timeout: ADC never responds at point (1,2) → data_out=12'hFFF there after 255 WAIT cycles, adc_err=1, scan continues; next start clears adc_err.
- Continuous: continuous=1 over 2 frames → 32 writes, frame_done pulses twice, sw_sel returns to 0 with no IDLE cycle.
- Abort mid-WAIT at point (2,1), with adc_valid in the same cycle → no write for (2,1), no frame_done, IDLE next cycle, sw_en=0.
- Async reset asserted during WRITE → all outputs 0 immediately. After release with start=1, the scan restarts at (0,0).
- Spurious adc_valid during SW_SETTLE and RD_SETTLE → ignored: no write, no state change.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// ADC conversion handshake and frame-storage write port of the tactile scan sequencer.
// The sequencer side uses the master modport; ADC and frame storage sit on the slave side.
interface scan_sequencer_if #(
  parameter int SW_W = 5,
  parameter int RD_W = 5
);
  logic            adc_start;
  logic            adc_valid;
  logic [11:0]     adc_data;
  logic [SW_W-1:0] sw_write_out;
  logic [RD_W-1:0] rd_write_out;
  logic [11:0]     data_out;
  logic            data_valid_out;

  modport master (
    output adc_start,
    input  adc_valid,
    input  adc_data,
    output sw_write_out,
    output rd_write_out,
    output data_out,
    output data_valid_out
  );

  modport slave (
    input  adc_start,
    output adc_valid,
    output adc_data,
    input  sw_write_out,
    input  rd_write_out,
    input  data_out,
    input  data_valid_out
  );
endinterface

// File: rtl/scan_sequencer.sv
// Write-side scan controller: walks every (switch, read) point row-major, settles, converts,
// and issues one storage write per point on the write clock domain.
module scan_sequencer #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int SW_SETTLE   = 64,
  parameter int RD_SETTLE   = 4,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic                           clk_write,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           abort,
  output logic                           sw_en,
  output logic [$clog2(SW_WIRE_CNT):0]   sw_sel,
  output logic [$clog2(RD_WIRE_CNT):0]   rd_sel,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           adc_err,
  scan_sequencer_if.master               bus
);

  localparam int SW_W    = $clog2(SW_WIRE_CNT) + 1;
  localparam int RD_W    = $clog2(RD_WIRE_CNT) + 1;
  localparam int CNT_A   = (SW_SETTLE > RD_SETTLE) ? SW_SETTLE : RD_SETTLE;
  localparam int CNT_MAX = (CNT_A > ADC_TIMEOUT) ? CNT_A : ADC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SW_SETTLE,
    S_RD_SETTLE,
    S_CONVERT,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [SW_W-1:0]   sw_next;
  logic [RD_W-1:0]   rd_next;
  logic              err_next;
  logic              done_next;
  logic              load_wr;
  logic [11:0]       sample_next;

  assign sw_en              = (state != S_IDLE);
  assign busy               = (state != S_IDLE);
  assign bus.adc_start      = (state == S_CONVERT);
  assign bus.data_valid_out = (state == S_WRITE);

  // One shared counter times every settle/wait phase; it is zeroed on each phase entry.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    sw_next     = sw_sel;
    rd_next     = rd_sel;
    err_next    = adc_err;
    done_next   = 1'b0;
    load_wr     = 1'b0;
    sample_next = bus.adc_data;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SW_SETTLE;
          cnt_next   = '0;
          sw_next    = '0;
          rd_next    = '0;
          err_next   = 1'b0;
        end
      end
      S_SW_SETTLE: begin
        if (cnt == CNT_W'(SW_SETTLE - 1)) begin
          state_next = S_RD_SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_RD_SETTLE: begin
        if (cnt == CNT_W'(RD_SETTLE - 1)) begin
          state_next = S_CONVERT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        state_next = S_WAIT;
        cnt_next   = '0;
      end
      S_WAIT: begin
        if (bus.adc_valid) begin
          state_next = S_WRITE;
          cnt_next   = '0;
          load_wr    = 1'b1;
        end else if (cnt == CNT_W'(ADC_TIMEOUT - 1)) begin
          state_next  = S_WRITE;
          cnt_next    = '0;
          load_wr     = 1'b1;
          sample_next = 12'hFFF;
          err_next    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        cnt_next = '0;
        if (rd_sel < RD_W'(RD_WIRE_CNT - 1)) begin
          rd_next    = rd_sel + RD_W'(1);
          state_next = S_RD_SETTLE;
        end else if (sw_sel < SW_W'(SW_WIRE_CNT - 1)) begin
          sw_next    = sw_sel + SW_W'(1);
          rd_next    = '0;
          state_next = S_SW_SETTLE;
        end else begin
          done_next = 1'b1;
          if (continuous) begin
            sw_next    = '0;
            rd_next    = '0;
            state_next = S_SW_SETTLE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Abort wins over everything: the in-flight sample and any pending frame_done are dropped.
    if (abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      sw_next    = sw_sel;
      rd_next    = rd_sel;
      err_next   = adc_err;
      done_next  = 1'b0;
      load_wr    = 1'b0;
    end
  end

  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      sw_sel           <= '0;
      rd_sel           <= '0;
      frame_done       <= 1'b0;
      adc_err          <= 1'b0;
      bus.sw_write_out <= '0;
      bus.rd_write_out <= '0;
      bus.data_out     <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sw_sel     <= sw_next;
      rd_sel     <= rd_next;
      frame_done <= done_next;
      adc_err    <= err_next;
      // Write payload is latched on entry to WRITE so it holds steady until the next point.
      if (load_wr) begin
        bus.sw_write_out <= sw_sel;
        bus.rd_write_out <= rd_sel;
        bus.data_out     <= sample_next;
      end
    end
  end

endmodule
